// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : EX stage of the in-order 32-bit pipeline. Selects the ALU
//            operands, evaluates the decoded ALU function and registers the
//            result with the pass-through fields into the EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int WORD     = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          opsel1,
  input  logic [1:0]          opsel2,
  input  logic [3:0]          alu_func,
  input  logic [WORD-1:0]     rs1_data_i,
  input  logic [WORD-1:0]     rs2_data_i,
  input  logic [WORD-1:0]     imm,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                rf_w_en_i,
  input  logic                mem_w_en_i,
  input  logic [1:0]          wbsel_i,
  output logic [WORD-1:0]     alu_out,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [4:0]          rd_addr_o,
  output logic                rf_w_en_o,
  output logic                mem_w_en_o,
  output logic [1:0]          wbsel_o,
  output logic [WORD-1:0]     rs2_data_o
);

  // Operand-A selects
  localparam logic [1:0] c_opa_rs1 = 2'b00;
  localparam logic [1:0] c_opa_pc  = 2'b01;
  // Operand-B selects
  localparam logic [1:0] c_opb_rs2 = 2'b00;
  localparam logic [1:0] c_opb_imm = 2'b01;
  localparam logic [1:0] c_opb_four = 2'b10;
  // ALU function codes
  localparam logic [3:0] c_alu_add   = 4'b0000;
  localparam logic [3:0] c_alu_sub   = 4'b0001;
  localparam logic [3:0] c_alu_sll   = 4'b0010;
  localparam logic [3:0] c_alu_slt   = 4'b0011;
  localparam logic [3:0] c_alu_sltu  = 4'b0100;
  localparam logic [3:0] c_alu_xor   = 4'b0101;
  localparam logic [3:0] c_alu_srl   = 4'b0110;
  localparam logic [3:0] c_alu_sra   = 4'b0111;
  localparam logic [3:0] c_alu_or    = 4'b1000;
  localparam logic [3:0] c_alu_and   = 4'b1001;
  localparam logic [3:0] c_alu_passb = 4'b1010;

  localparam logic [WORD-1:0] c_link_inc = WORD'(4);

  logic [WORD-1:0] w_pc_word;
  logic [WORD-1:0] w_op_a;
  logic [WORD-1:0] w_op_b;
  logic [4:0]      w_shamt;
  logic [WORD-1:0] w_alu_res;

  // PC is fitted to the datapath width: truncated when wider, zero-extended when narrower
  generate
    if (ADDR_LEN >= WORD) begin : g_pc_trunc
      assign w_pc_word = pc_i[WORD-1:0];
    end else begin : g_pc_zext
      assign w_pc_word = {{(WORD-ADDR_LEN){1'b0}}, pc_i};
    end
  endgenerate

  // Operand A mux; the two unused encodings read as zero
  always_comb begin
    w_op_a = '0;
    case (opsel1)
      c_opa_rs1: w_op_a = rs1_data_i;
      c_opa_pc:  w_op_a = w_pc_word;
      default:   w_op_a = '0;
    endcase
  end

  // Operand B mux; constant 4 builds the link address for jumps
  always_comb begin
    w_op_b = '0;
    case (opsel2)
      c_opb_rs2:  w_op_b = rs2_data_i;
      c_opb_imm:  w_op_b = imm;
      c_opb_four: w_op_b = c_link_inc;
      default:    w_op_b = '0;
    endcase
  end

  // Only the low five bits of operand B set the shift distance
  assign w_shamt = w_op_b[4:0];

  // ALU function decode; reserved codes produce zero
  always_comb begin
    w_alu_res = '0;
    case (alu_func)
      c_alu_add:   w_alu_res = w_op_a + w_op_b;
      c_alu_sub:   w_alu_res = w_op_a - w_op_b;
      c_alu_sll:   w_alu_res = w_op_a << w_shamt;
      c_alu_slt:   w_alu_res = {{(WORD-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      c_alu_sltu:  w_alu_res = {{(WORD-1){1'b0}}, (w_op_a < w_op_b)};
      c_alu_xor:   w_alu_res = w_op_a ^ w_op_b;
      c_alu_srl:   w_alu_res = w_op_a >> w_shamt;
      c_alu_sra:   w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
      c_alu_or:    w_alu_res = w_op_a | w_op_b;
      c_alu_and:   w_alu_res = w_op_a & w_op_b;
      c_alu_passb: w_alu_res = w_op_b;
      default:     w_alu_res = '0;
    endcase
  end

  // EX/MEM pipeline register; reset inserts a bubble with every field cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_out    <= '0;
      pc_o       <= '0;
      rd_addr_o  <= '0;
      rf_w_en_o  <= 1'b0;
      mem_w_en_o <= 1'b0;
      wbsel_o    <= '0;
      rs2_data_o <= '0;
    end else begin
      alu_out    <= w_alu_res;
      pc_o       <= pc_i;
      rd_addr_o  <= rd_addr_i;
      rf_w_en_o  <= rf_w_en_i;
      mem_w_en_o <= mem_w_en_i;
      wbsel_o    <= wbsel_i;
      rs2_data_o <= rs2_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Self-checking bench for execute_stage: directed vectors with
//            literal expectations plus a per-cycle reference model compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  opsel1, opsel2;
  logic [3:0]  alu_func;
  logic [31:0] rs1_data_i, rs2_data_i, imm, pc_i;
  logic [4:0]  rd_addr_i;
  logic        rf_w_en_i, mem_w_en_i;
  logic [1:0]  wbsel_i;
  logic [31:0] alu_out, pc_o, rs2_data_o;
  logic [4:0]  rd_addr_o;
  logic        rf_w_en_o, mem_w_en_o;
  logic [1:0]  wbsel_o;

  int checks = 0;
  int errors = 0;

  execute_stage #(.WORD(32), .ADDR_LEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opsel1     (opsel1),
    .opsel2     (opsel2),
    .alu_func   (alu_func),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .imm        (imm),
    .pc_i       (pc_i),
    .rd_addr_i  (rd_addr_i),
    .rf_w_en_i  (rf_w_en_i),
    .mem_w_en_i (mem_w_en_i),
    .wbsel_i    (wbsel_i),
    .alu_out    (alu_out),
    .pc_o       (pc_o),
    .rd_addr_o  (rd_addr_o),
    .rf_w_en_o  (rf_w_en_o),
    .mem_w_en_o (mem_w_en_o),
    .wbsel_o    (wbsel_o),
    .rs2_data_o (rs2_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference ALU written from the instruction semantics
  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = int'(b % 32);
    case (f)
      4'd0:  return a + b;
      4'd1:  return a + (~b + 32'd1);
      4'd2:  return a * (32'd1 << sh);
      4'd3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a / (32'd1 << sh);
      4'd7: begin
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return (a >> sh) | fill;
      end
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Model state: what the EX/MEM register must hold after the latest edge
  logic        model_valid = 1'b0;
  logic [31:0] m_alu, m_pc, m_rs2;
  logic [4:0]  m_rd;
  logic        m_rf, m_mem;
  logic [1:0]  m_wb;

  // Model update at each rising edge from the inputs present before it
  always @(posedge clk) begin
    logic [31:0] a, b;
    a = (opsel1 == 2'd0) ? rs1_data_i : (opsel1 == 2'd1) ? pc_i : 32'd0;
    b = (opsel2 == 2'd0) ? rs2_data_i : (opsel2 == 2'd1) ? imm :
        (opsel2 == 2'd2) ? 32'd4 : 32'd0;
    if (reset === 1'b0) begin
      m_alu <= 0; m_pc <= 0; m_rs2 <= 0; m_rd <= 0; m_rf <= 0; m_mem <= 0; m_wb <= 0;
    end else begin
      m_alu <= ref_alu(alu_func, a, b);
      m_pc  <= pc_i;
      m_rs2 <= rs2_data_i;
      m_rd  <= rd_addr_i;
      m_rf  <= rf_w_en_i;
      m_mem <= mem_w_en_i;
      m_wb  <= wbsel_i;
    end
    model_valid <= 1'b1;
  end

  // Per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_alu_out",  alu_out,    m_alu);
      chk("m_pc_o",     pc_o,       m_pc);
      chk("m_rs2_o",    rs2_data_o, m_rs2);
      chk("m_rd_o",     {27'd0, rd_addr_o},  {27'd0, m_rd});
      chk("m_rf_en",    {31'd0, rf_w_en_o},  {31'd0, m_rf});
      chk("m_mem_en",   {31'd0, mem_w_en_o}, {31'd0, m_mem});
      chk("m_wbsel",    {30'd0, wbsel_o},    {30'd0, m_wb});
    end
  end

  // Apply one ALU vector, let one edge pass, then check alu_out against a literal
  task automatic alu_vec(input string name, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [3:0] f, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] pc,
                         input logic [31:0] exp);
    opsel1 = s1; opsel2 = s2; alu_func = f;
    rs1_data_i = r1; rs2_data_i = r2; imm = im; pc_i = pc;
    @(posedge clk);
    @(negedge clk);
    chk(name, alu_out, exp);
  endtask

  initial begin
    // Reset with live, nonzero inputs
    reset = 1'b0;
    opsel1 = 2'd0; opsel2 = 2'd0; alu_func = 4'd0;
    rs1_data_i = 32'd9; rs2_data_i = 32'd7; imm = 32'd3; pc_i = 32'h40;
    rd_addr_i = 5'd5; rf_w_en_i = 1'b1; mem_w_en_i = 1'b1; wbsel_i = 2'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu",  alu_out, 32'd0);
    chk("rst_rd",   {27'd0, rd_addr_o}, 32'd0);
    chk("rst_rf",   {31'd0, rf_w_en_o}, 32'd0);
    chk("rst_mem",  {31'd0, mem_w_en_o}, 32'd0);
    chk("rst_pc",   pc_o, 32'd0);
    chk("rst_rs2",  rs2_data_o, 32'd0);

    reset = 1'b1;
    rf_w_en_i = 1'b0; mem_w_en_i = 1'b0; rd_addr_i = 5'd1; wbsel_i = 2'd0;
    alu_vec("add_rr",  2'd0, 2'd0, 4'd0, 32'd4, 32'd2, 32'd0, 32'd1, 32'd6);
    chk("add_pc_o", pc_o, 32'd1);
    alu_vec("sub_neg", 2'd0, 2'd0, 4'd1, 32'd4, 32'd6, 32'd0, 32'd1, 32'hFFFF_FFFE);
    alu_vec("pc_plus4", 2'd1, 2'd2, 4'd0, 32'd0, 32'd0, 32'd0, 32'h100, 32'h104);
    alu_vec("add_imm", 2'd0, 2'd1, 4'd0, 32'h10, 32'd0, 32'hFFFF_FFF0, 32'd0, 32'd0);
    alu_vec("sra",     2'd0, 2'd1, 4'd7, 32'h8000_0000, 32'd0, 32'h21, 32'd0, 32'hC000_0000);
    alu_vec("srl",     2'd0, 2'd1, 4'd6, 32'h8000_0000, 32'd0, 32'h21, 32'd0, 32'h4000_0000);
    alu_vec("slt",     2'd0, 2'd1, 4'd3, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd1);
    alu_vec("sltu",    2'd0, 2'd1, 4'd4, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd0);
    alu_vec("passb",   2'd0, 2'd1, 4'd10, 32'h5555, 32'd0, 32'h1234_5000, 32'd0, 32'h1234_5000);
    alu_vec("sll",     2'd0, 2'd1, 4'd2, 32'd1, 32'd0, 32'h25, 32'd0, 32'h20);
    alu_vec("xor",     2'd0, 2'd0, 4'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'd0, 32'hFF00_0FF0);
    alu_vec("or",      2'd0, 2'd0, 4'd8, 32'hF000_0001, 32'h0000_0F00, 32'd0, 32'd0, 32'hF000_0F01);
    alu_vec("and",     2'd0, 2'd0, 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 32'hF000_F000);
    alu_vec("opa_zero", 2'd2, 2'd0, 4'd0, 32'h1111, 32'd5, 32'd0, 32'h200, 32'd5);
    alu_vec("opb_zero", 2'd0, 2'd3, 4'd0, 32'h1111, 32'd5, 32'd9, 32'd0, 32'h1111);
    alu_vec("rsvd_op", 2'd0, 2'd0, 4'd12, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0);

    // Pass-through fields; rs2 store data is independent of opsel2
    rd_addr_i = 5'd31; rf_w_en_i = 1'b1; mem_w_en_i = 1'b1; wbsel_i = 2'd2;
    alu_vec("pt_alu",  2'd0, 2'd1, 4'd0, 32'd1, 32'hDEAD_BEEF, 32'd2, 32'h80, 32'd3);
    chk("pt_rs2",  rs2_data_o, 32'hDEAD_BEEF);
    chk("pt_rd",   {27'd0, rd_addr_o}, 32'd31);
    chk("pt_rf",   {31'd0, rf_w_en_o}, 32'd1);
    chk("pt_mem",  {31'd0, mem_w_en_o}, 32'd1);
    chk("pt_wb",   {30'd0, wbsel_o}, 32'd2);

    // Back-to-back, with a reset bubble in cycle 3
    rf_w_en_i = 1'b1; mem_w_en_i = 1'b0; wbsel_i = 2'd1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_alu, exp_pc;
      reset = (i == 2) ? 1'b0 : 1'b1;
      rd_addr_i = 5'(i + 10);
      exp_alu = (i == 2) ? 32'd0 : 32'(3 * (i + 1) + 100);
      exp_pc  = (i == 2) ? 32'd0 : 32'(32'h1000 + 4 * i);
      alu_vec("b2b_alu", 2'd0, 2'd0, 4'd0, 32'(i + 1), 32'(2 * (i + 1) + 100), 32'd0,
              32'(32'h1000 + 4 * i), exp_alu);
      chk("b2b_pc", pc_o, exp_pc);
      chk("b2b_rd", {27'd0, rd_addr_o}, (i == 2) ? 32'd0 : 32'(i + 10));
    end
    reset = 1'b1;

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the in-order 32-bit RISC-V-style pipeline. It selects two ALU operands from the register-file data, immediate, PC or constants, and performs the decoded ALU function. It registers the result, together with the pass-through control and data fields, into the EX/MEM pipeline register for the memory and write-back stages. The RTL module is named `execute_stage`.

## Interface
Parameters:
- WORD, default 32: datapath width (ALU operands, result, register data, immediate).
- ADDR_LEN, default 32: PC width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- opsel1  in  2  operand-A select.
- opsel2  in  2  operand-B select.
- alu_func  in  4  ALU operation code.
- rs1_data_i  in  WORD  source register 1 data.
- rs2_data_i  in  WORD  source register 2 data.
- imm  in  WORD  sign-extended immediate.
- pc_i  in  ADDR_LEN  PC of the instruction in EX.
- rd_addr_i  in  5  destination register index.
- rf_w_en_i  in  1  register-file write enable.
- mem_w_en_i  in  1  data-memory write enable.
- wbsel_i  in  2  write-back source select (opaque here).
- alu_out  out  WORD  registered ALU result.
- pc_o  out  ADDR_LEN  registered pc_i.
- rd_addr_o  out  5  registered rd_addr_i.
- rf_w_en_o  out  1  registered rf_w_en_i.
- mem_w_en_o  out  1  registered mem_w_en_i.
- wbsel_o  out  2  registered wbsel_i.
- rs2_data_o  out  WORD  registered rs2_data_i (store data).

## Operation
- Operand A (opsel1):
  - 00: rs1_data_i
  - 01: pc_i, zero-extended or truncated to WORD
  - 10 and 11: zero
- Operand B (opsel2):
  - 00: rs2_data_i
  - 01: imm
  - 10: constant 4 (link address)
  - 11: zero
- ALU (alu_func), combinational, WORD-bit, wrap-around arithmetic with no overflow flag:
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 SLL: A << B[4:0]
  - 0011 SLT: signed A<B → 1, else 0
  - 0100 SLTU: unsigned compare, same result encoding
  - 0101 XOR
  - 0110 SRL: logical shift right by B[4:0]
  - 0111 SRA: arithmetic shift right by B[4:0]
  - 1000 OR
  - 1001 AND
  - 1010 PASSB: B (LUI)
  - 1011–1111: result 0
- Shift amount uses only B[4:0]; the upper bits are ignored.
- All outputs come from flops. No stall, flush or handshake; the stage accepts a new instruction every cycle.
- pc_o, rd_addr_o, rf_w_en_o, mem_w_en_o, wbsel_o and rs2_data_o are copied unmodified. rs2_data_o always carries rs2_data_i, independent of opsel2.

## Timing
- Latency 1 cycle: inputs sampled at rising edge N appear on outputs after edge N and hold until edge N+1.
- Reset: when reset=0 at a rising edge, every output register clears to 0, giving alu_out=0, pc_o=0, rd_addr_o=0, rf_w_en_o=0, mem_w_en_o=0, wbsel_o=0, rs2_data_o=0. This is a bubble with no architectural side effect.
- Reset has priority over the inputs. Asserting it mid-stream discards the instruction sampled at that edge.
- Reset deassertion: the first instruction is captured at the first edge with reset=1.
- Outputs do not change between edges; input glitches between edges are invisible.
- Simultaneous input changes at an edge follow normal setup semantics: the values present before the edge are captured.

## Test plan
- Reset: hold reset=0 for 2 edges with nonzero inputs (rf_w_en_i=1, mem_w_en_i=1, rd_addr_i=5) → all outputs 0.
- Register-register, reset=1:
  - opsel1=00, opsel2=00, alu_func=0000, rs1=4, rs2=2, pc_i=1 → alu_out=6, pc_o=1 one edge later.
  - Then alu_func=0001 with rs1=4, rs2=6 → alu_out=0xFFFFFFFE.
- Immediate and PC operands:
  - opsel1=01, opsel2=10, pc_i=0x100, alu_func=0000 → alu_out=0x104.
  - opsel1=00, opsel2=01, rs1=0x10, imm=0xFFFFFFF0, ADD → alu_out=0.
- Shifts and compares:
  - A=0x80000000, B=0x21 → SRA gives 0xC0000000, SRL gives 0x40000000.
  - A=0xFFFFFFFF, B=1 → SLT gives 1, SLTU gives 0.
  - PASSB with imm=0x12345000 → alu_out=0x12345000.
- Pass-through: rd_addr_i=31, rf_w_en_i=1, mem_w_en_i=1, wbsel_i=2, rs2_data_i=0xDEADBEEF, opsel2=01 → outputs equal these values after 1 edge, with rs2_data_o=0xDEADBEEF.
- Back-to-back: change inputs every cycle for 4 cycles → each output matches the previous cycle's inputs. Assert reset=0 in cycle 3 → that cycle's outputs are 0 and cycle 4 resumes normally.
